// File: rtl/tsv_fmap_ctrl_pkg.sv
// Shared constants, controller state encoding and popcount helper for the TSV fault-map path.
// Parity checking of incoming maps is enabled by defining FMAP_PARITY_CHK_EN.
package tsv_ctrl_pkg;

    localparam int NTSV_DEF = 9;
    localparam int NRED_DEF = 1;
    localparam int NTSV_MAX = 64;

    typedef enum logic [1:0] {
        RUN,
        DRAIN,
        LOAD,
        SETTLE
    } fmap_state_t;

    function automatic int popcount_ntsv(input logic [NTSV_MAX-1:0] v);
        int c;
        c = 0;
        for (int i = 0; i < NTSV_MAX; i++) begin
            c += int'(v[i]);
        end
        return c;
    endfunction

endpackage

// File: rtl/tsv_fmap_ctrl_if.sv
// Handshake and data-path bundle between the link manager and the fault-map controller.
// The fmap_par member exists only when FMAP_PARITY_CHK_EN is defined.
interface tsv_fmap_ctrl_if #(
    parameter int NTSV = 9
);

    logic            fmap_valid;
    logic            fmap_ready;
    logic [NTSV-1:0] fmap_data;
`ifdef FMAP_PARITY_CHK_EN
    logic            fmap_par;
`endif
    logic            fmap_ack;
    logic            fmap_nack;
    logic            din_valid;
    logic            din_ready;
    logic            coder_en;
    logic            dout_valid;
    logic [NTSV-1:0] f_flag;
    logic            busy;

    modport master (
        output fmap_valid,
        output fmap_data,
`ifdef FMAP_PARITY_CHK_EN
        output fmap_par,
`endif
        output din_valid,
        input  fmap_ready,
        input  fmap_ack,
        input  fmap_nack,
        input  din_ready,
        input  coder_en,
        input  dout_valid,
        input  f_flag,
        input  busy
    );

    modport slave (
        input  fmap_valid,
        input  fmap_data,
`ifdef FMAP_PARITY_CHK_EN
        input  fmap_par,
`endif
        input  din_valid,
        output fmap_ready,
        output fmap_ack,
        output fmap_nack,
        output din_ready,
        output coder_en,
        output dout_valid,
        output f_flag,
        output busy
    );

endinterface

// File: rtl/tsv_fmap_ctrl_check.sv
// Combinational classifier for a requested fault map: reject, same as current, or accept.
// With FMAP_PARITY_CHK_EN defined, an even-parity mismatch also rejects the map.
module tsv_fmap_check
    import tsv_ctrl_pkg::*;
#(
    parameter int NTSV = NTSV_DEF,
    parameter int NRED = NRED_DEF
) (
    input  logic [NTSV-1:0] fmap_data,
    input  logic [NTSV-1:0] f_flag,
`ifdef FMAP_PARITY_CHK_EN
    input  logic            fmap_par,
`endif
    output logic            reject,
    output logic            same,
    output logic            accept
);

    logic [NTSV_MAX-1:0] ext;
    logic                over;
    logic                par_bad;

    always_comb begin
        ext            = '0;
        ext[NTSV-1:0]  = fmap_data;
        over           = popcount_ntsv(ext) > NRED;
`ifdef FMAP_PARITY_CHK_EN
        par_bad        = fmap_par != (^fmap_data);
`else
        par_bad        = 1'b0;
`endif
        reject         = over | par_bad;
        same           = !reject && (fmap_data == f_flag);
        accept         = !reject && !same;
    end

endmodule

// File: rtl/tsv_fmap_ctrl.sv
// Fault-map update sequencer: gates coder capture, drains in-flight words, swaps f_flag, settles.
// Build option FMAP_PARITY_CHK_EN adds an even-parity check on requested maps.
module tsv_fmap_ctrl
    import tsv_ctrl_pkg::*;
#(
    parameter int NTSV       = NTSV_DEF,
    parameter int NRED       = NRED_DEF,
    parameter int LAT        = 1,
    parameter int SETTLE_CYC = 2
) (
    input  logic          clock,
    input  logic          reset,
    tsv_fmap_ctrl_if.slave bus
);

    localparam int CW = (LAT > 0) ? $clog2(LAT + 1) : 1;
    localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;

    fmap_state_t     state;
    fmap_state_t     state_nxt;
    logic [NTSV-1:0] f_flag_q;
    logic [NTSV-1:0] pend_q;
    logic [CW-1:0]   infl;
    logic [SW-1:0]   scnt;
    logic            ack_q;
    logic            nack_q;
    logic            ack_nxt;
    logic            nack_nxt;
    logic            settle_ack;
    logic            load_pend;
    logic            in_run;
    logic            hs;
    logic            coder_en;
    logic            reject;
    logic            same;
    logic            accept;

    tsv_fmap_check #(
        .NTSV (NTSV),
        .NRED (NRED)
    ) u_check (
        .fmap_data (bus.fmap_data),
        .f_flag    (f_flag_q),
`ifdef FMAP_PARITY_CHK_EN
        .fmap_par  (bus.fmap_par),
`endif
        .reject    (reject),
        .same      (same),
        .accept    (accept)
    );

    assign in_run   = (state == RUN);
    assign hs       = bus.fmap_valid & in_run;
    assign coder_en = bus.din_valid & in_run;

    assign bus.fmap_ready = in_run;
    assign bus.din_ready  = in_run;
    assign bus.coder_en   = coder_en;
    assign bus.busy       = !in_run;
    assign bus.f_flag     = f_flag_q;
    assign bus.fmap_nack  = nack_q;
    // Swap completion acks on the last SETTLE cycle, not the first RUN cycle
    assign bus.fmap_ack   = ack_q | settle_ack;

    always_comb begin
        state_nxt  = state;
        ack_nxt    = 1'b0;
        nack_nxt   = 1'b0;
        settle_ack = 1'b0;
        load_pend  = 1'b0;
        unique case (state)
            RUN: begin
                if (hs) begin
                    if (reject) begin
                        nack_nxt = 1'b1;
                    end else if (same) begin
                        ack_nxt = 1'b1;
                    end else if (accept) begin
                        load_pend = 1'b1;
                        state_nxt = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (infl == '0) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                state_nxt = SETTLE;
            end
            SETTLE: begin
                if (scnt == '0) begin
                    state_nxt  = RUN;
                    settle_ack = 1'b1;
                end
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= RUN;
            ack_q  <= 1'b0;
            nack_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            ack_q  <= ack_nxt;
            nack_q <= nack_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_q   <= '0;
            f_flag_q <= '0;
        end else begin
            if (load_pend) begin
                pend_q <= bus.fmap_data;
            end
            if (state == LOAD) begin
                f_flag_q <= pend_q;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            scnt <= '0;
        end else if (state == LOAD) begin
            scnt <= SW'(SETTLE_CYC - 1);
        end else if (state == SETTLE && scnt != '0) begin
            scnt <= scnt - 1'b1;
        end
    end

    // Counts words captured by the coder but not yet out of the decoder
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            infl <= '0;
        end else begin
            unique case ({coder_en, bus.dout_valid})
                2'b10: begin
                    if (infl != CW'(LAT)) begin
                        infl <= infl + 1'b1;
                    end
                end
                2'b01: begin
                    if (infl != '0) begin
                        infl <= infl - 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    if (LAT == 0) begin : g_nolat
        assign bus.dout_valid = coder_en;
    end else begin : g_lat
        logic [LAT-1:0] sh;
        always_ff @(posedge clock or posedge reset) begin
            if (reset) begin
                sh <= '0;
            end else begin
                sh <= (sh << 1) | LAT'(coder_en);
            end
        end
        assign bus.dout_valid = sh[LAT-1];
    end

endmodule
